// File: rtl/time_ctrl.sv
// Time-of-day keeper: RUN counts seconds from tick_1hz, SET_H/SET_M/SET_S edit one field.
// count is the registered seconds-since-midnight view of the fields; chime marks each hour rollover.
module time_ctrl #(
    parameter int DAY_SECONDS = 86400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        mode_btn,
    input  logic        inc_btn,
    output logic [16:0] count,
    output logic [1:0]  mode,
    output logic        chime
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] SET_H = 2'd1;
    localparam logic [1:0] SET_M = 2'd2;
    localparam logic [1:0] SET_S = 2'd3;
    localparam logic [4:0] HRS_MAX = 5'(DAY_SECONDS / 3600 - 1);

    logic [1:0] state, state_n;
    logic [4:0] hrs, hrs_n;
    logic [5:0] mins, mins_n;
    logic [5:0] secs, secs_n;
    logic       chime_n;
    logic       edit;

    // a mode press in the same cycle swallows the edit
    assign edit = inc_btn && !mode_btn;

    always_comb begin
        state_n = state;
        hrs_n   = hrs;
        mins_n  = mins;
        secs_n  = secs;
        chime_n = 1'b0;
        case (state)
            RUN: begin
                if (mode_btn) state_n = SET_H;
                if (tick_1hz) begin
                    if (secs == 6'd59) begin
                        secs_n = 6'd0;
                        if (mins == 6'd59) begin
                            mins_n  = 6'd0;
                            hrs_n   = (hrs == HRS_MAX) ? 5'd0 : hrs + 5'd1;
                            chime_n = 1'b1;
                        end else begin
                            mins_n = mins + 6'd1;
                        end
                    end else begin
                        secs_n = secs + 6'd1;
                    end
                end
            end
            SET_H: begin
                if (mode_btn) state_n = SET_M;
                if (edit) hrs_n = (hrs == HRS_MAX) ? 5'd0 : hrs + 5'd1;
            end
            SET_M: begin
                if (mode_btn) state_n = SET_S;
                if (edit) mins_n = (mins == 6'd59) ? 6'd0 : mins + 6'd1;
            end
            SET_S: begin
                if (mode_btn) state_n = RUN;
                if (edit) secs_n = 6'd0;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            hrs   <= 5'd0;
            mins  <= 6'd0;
            secs  <= 6'd0;
            count <= 17'd0;
            chime <= 1'b0;
        end else begin
            state <= state_n;
            hrs   <= hrs_n;
            mins  <= mins_n;
            secs  <= secs_n;
            chime <= chime_n;
            // built from the current fields, so count trails a field update by one cycle
            count <= 17'(hrs) * 17'd3600 + 17'(mins) * 17'd60 + 17'(secs);
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_time_ctrl.sv
// Bench for time_ctrl: seconds-of-day reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_time_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        mode_btn = 1'b0;
    logic        inc_btn = 1'b0;
    logic [16:0] count;
    logic [1:0]  mode;
    logic        chime;

    time_ctrl #(.DAY_SECONDS(86400)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_btn(mode_btn),
        .inc_btn(inc_btn), .count(count), .mode(mode), .chime(chime)
    );

    always #5 clk = ~clk;

    // reference: time held as plain seconds since midnight
    int   m_sec = 0;
    int   m_mode = 0;
    int   exp_count = 0;
    logic exp_chime = 1'b0;

    function automatic int edit_sec(input int s, input int md);
        int h  = s / 3600;
        int mi = (s / 60) % 60;
        int se = s % 60;
        case (md)
            1:       h  = (h + 1) % 24;
            2:       mi = (mi + 1) % 60;
            default: se = 0;
        endcase
        return h * 3600 + mi * 60 + se;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_sec     <= 0;
            m_mode    <= 0;
            exp_count <= 0;
            exp_chime <= 1'b0;
        end else begin
            exp_count <= m_sec;
            exp_chime <= 1'b0;
            if (mode_btn) m_mode <= (m_mode + 1) % 4;
            if (m_mode == 0 && tick_1hz) begin
                m_sec     <= (m_sec + 1) % 86400;
                exp_chime <= ((m_sec + 1) % 3600 == 0);
            end else if (m_mode != 0 && inc_btn && !mode_btn) begin
                m_sec <= edit_sec(m_sec, m_mode);
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int chime_total = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one clock: drive inputs, let the edge happen, compare outputs against the model
    task automatic cyc(input logic r, input logic t, input logic m, input logic i);
        rst = r; tick_1hz = t; mode_btn = m; inc_btn = i;
        @(negedge clk);
        if (cmp_en) begin
            check("model_count", 32'(count), 32'(exp_count));
            check("model_mode", 32'(mode), 32'(m_mode));
            check("model_chime", 32'(chime), 32'(exp_chime));
        end
        if (chime === 1'b1) chime_total++;
    endtask

    task automatic run(input int n, input logic t, input logic m, input logic i);
        for (int k = 0; k < n; k++) cyc(1'b0, t, m, i);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // from RUN at 00:00:00, dial in h:mi:00 and return to RUN
    task automatic set_time(input int h, input int mi);
        run(1, 1'b0, 1'b1, 1'b0);
        run(h, 1'b0, 1'b0, 1'b1);
        run(1, 1'b0, 1'b1, 1'b0);
        run(mi, 1'b0, 1'b0, 1'b1);
        run(2, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int c0;
        cmp_en = 1'b1;
        run(2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_count", 32'(count), 0);
        check("reset_mode", 32'(mode), 0);
        check("reset_chime", 32'(chime), 0);

        // first tick after reset, then 61 ticks total
        c0 = chime_total;
        run(1, 1'b1, 1'b0, 1'b0);
        idle();
        check("first_tick", 32'(count), 1);
        run(60, 1'b1, 1'b0, 1'b0);
        idle();
        check("ticks_61", 32'(count), 61);
        check("no_chime_61", 32'(chime_total - c0), 0);

        // 10:30:15, then SET-mode edits
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        set_time(10, 30);
        run(15, 1'b1, 1'b0, 1'b0);
        idle();
        check("at_103015", 32'(count), 37815);
        check("model_pin_103015", 32'(m_sec), 37815);
        c0 = chime_total;
        run(1, 1'b0, 1'b1, 1'b0);
        run(3, 1'b0, 1'b0, 1'b1);
        idle();
        check("set_h_mode", 32'(mode), 1);
        check("set_h_plus3", 32'(count), 48615);
        run(5, 1'b1, 1'b0, 1'b0);
        idle();
        check("frozen_in_set", 32'(count), 48615);
        run(1, 1'b0, 1'b1, 1'b0);
        run(29, 1'b0, 1'b0, 1'b1);
        idle();
        check("mins_59", 32'(count), 50355);
        run(1, 1'b0, 1'b0, 1'b1);
        idle();
        check("mins_wrap_no_carry", 32'(count), 46815);
        run(1, 1'b0, 1'b1, 1'b0);
        run(1, 1'b0, 1'b0, 1'b1);
        idle();
        check("secs_clear", 32'(count), 46800);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        check("set_s_tick_mode", 32'(mode), 0);
        check("set_s_tick_ignored", 32'(count), 46800);

        // tick+mode in RUN applies the tick; mode+inc drops the inc
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        check("run_tick_mode_cnt", 32'(count), 46801);
        check("run_tick_mode_st", 32'(mode), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        check("mode_inc_prio_st", 32'(mode), 2);
        check("mode_inc_prio_cnt", 32'(count), 46801);

        // hours wrap 23 -> 0 in SET_H
        run(3, 1'b0, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0, 1'b1);
        idle();
        check("hrs_23", 32'(count), 82801);
        run(1, 1'b0, 1'b0, 1'b1);
        idle();
        check("hrs_wrap", 32'(count), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        check("hrs_wrap_adv_st", 32'(mode), 2);
        check("hrs_wrap_adv_cnt", 32'(count), 1);
        check("no_chime_set", 32'(chime_total - c0), 0);

        // reset mid-edit in SET_M
        run(5, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_mid_mode", 32'(mode), 0);
        check("rst_mid_count", 32'(count), 0);
        check("rst_mid_chime", 32'(chime), 0);
        run(1, 1'b1, 1'b0, 1'b0);
        idle();
        check("rst_mid_first_tick", 32'(count), 1);

        // 01:59:59 -> 02:00:00
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        set_time(1, 59);
        run(59, 1'b1, 1'b0, 1'b0);
        idle();
        check("at_015959", 32'(count), 7199);
        c0 = chime_total;
        run(1, 1'b1, 1'b0, 1'b0);
        check("chime_hour", 32'(chime), 1);
        idle();
        check("at_020000", 32'(count), 7200);
        check("chime_hour_once", 32'(chime_total - c0), 1);

        // 23:59:59 -> 00:00:00
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        set_time(23, 59);
        run(59, 1'b1, 1'b0, 1'b0);
        idle();
        check("at_235959", 32'(count), 86399);
        check("model_pin_235959", 32'(m_sec), 86399);
        c0 = chime_total;
        run(1, 1'b1, 1'b0, 1'b0);
        check("chime_midnight", 32'(chime), 1);
        idle();
        check("midnight_wrap", 32'(count), 0);
        check("chime_midnight_once", 32'(chime_total - c0), 1);

        // reset wins over every other input
        run(3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        idle();
        check("rst_override_mode", 32'(mode), 0);
        check("rst_override_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
